// File: rtl/pmod_audio_axi_regs.sv
// pmod_audio_axi_regs: AXI4-Lite register file for the Pmod audio core
// Ports:
//   S_AXI_*        AXI4-Lite slave (clock, sync active-low reset, AW/W/B/AR/R channels)
//   audio_enable   CTRL[0]
//   audio_mute     CTRL[1]
//   audio_volume   CTRL[15:8]
//   audio_clkdiv   CLKDIV[15:0]
//   tx_data        current TX_SAMPLE value
//   tx_valid       sample pending for the core
//   tx_ready       core accepts the pending sample
module pmod_audio_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            audio_enable,
    output logic                            audio_mute,
    output logic [7:0]                      audio_volume,
    output logic [15:0]                     audio_clkdiv,
    output logic [31:0]                     tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready
);
    logic        r_ready_en;
    logic        r_aw_held;
    logic [1:0]  r_aw_addr;
    logic        r_w_held;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_enable;
    logic        r_mute;
    logic [7:0]  r_volume;
    logic [15:0] r_clkdiv;
    logic [31:0] r_tx_data;
    logic        r_tx_valid;
    logic        r_overrun;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [1:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_tx_commit;
    logic        w_set_ovr;
    logic        w_clr_ovr;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies stay low until the first clock edge after reset is released.
    assign S_AXI_AWREADY = r_ready_en & ~r_aw_held & ~r_bvalid;
    assign S_AXI_WREADY  = r_ready_en & ~r_w_held & ~r_bvalid;
    assign S_AXI_ARREADY = r_ready_en & ~r_rvalid;

    assign w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    // Commit as soon as both halves exist, latched or arriving this edge.
    assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_addr   = r_aw_held ? r_aw_addr : S_AXI_AWADDR[3:2];
    assign w_data   = r_w_held ? r_w_data : S_AXI_WDATA;
    assign w_strb   = r_w_held ? r_w_strb : S_AXI_WSTRB;

    assign w_tx_commit = w_commit & (w_addr == 2'd2);
    assign w_set_ovr   = w_tx_commit & r_tx_valid & ~tx_ready;
    assign w_clr_ovr   = w_commit & (w_addr == 2'd3) & w_strb[0] & w_data[1];

    always_comb begin
        w_rd_mux = (S_AXI_ARADDR[3:2] == 2'd0) ? {16'h0, r_volume, 6'h0, r_mute, r_enable} :
                   (S_AXI_ARADDR[3:2] == 2'd1) ? {16'h0, r_clkdiv} :
                   (S_AXI_ARADDR[3:2] == 2'd2) ? r_tx_data :
                                                 {30'h0, r_overrun, r_tx_valid};
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_ready_en <= 1'b0;
            r_aw_held  <= 1'b0;
            r_aw_addr  <= 2'd0;
            r_w_held   <= 1'b0;
            r_w_data   <= 32'h0;
            r_w_strb   <= 4'h0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'h0;
            r_enable   <= 1'b0;
            r_mute     <= 1'b0;
            r_volume   <= 8'h0;
            r_clkdiv   <= 16'h0007;
            r_tx_data  <= 32'h0;
            r_tx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
            end
            r_bvalid <= w_commit | (r_bvalid & ~S_AXI_BREADY);
            if (w_commit && w_addr == 2'd0) begin
                if (w_strb[0]) {r_mute, r_enable} <= w_data[1:0];
                if (w_strb[1]) r_volume <= w_data[15:8];
            end
            if (w_commit && w_addr == 2'd1) begin
                if (w_strb[0]) r_clkdiv[7:0]  <= w_data[7:0];
                if (w_strb[1]) r_clkdiv[15:8] <= w_data[15:8];
            end
            if (w_tx_commit) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) r_tx_data[8*b +: 8] <= w_data[8*b +: 8];
            end
            // A new sample always leaves tx_valid set, even if the old one is consumed now.
            r_tx_valid <= w_tx_commit ? 1'b1 : (r_tx_valid & ~tx_ready);
            r_overrun  <= w_set_ovr ? 1'b1 : (w_clr_ovr ? 1'b0 : r_overrun);
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RRESP  = 2'b00;
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign audio_enable = r_enable;
    assign audio_mute   = r_mute;
    assign audio_volume = r_volume;
    assign audio_clkdiv = r_clkdiv;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
endmodule

// File: tb/tb_pmod_audio_axi_regs.sv
// tb_pmod_audio_axi_regs: self-checking bench for the Pmod audio AXI4-Lite register file
module tb_pmod_audio_axi_regs;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        audio_enable;
    logic        audio_mute;
    logic [7:0]  audio_volume;
    logic [15:0] audio_clkdiv;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[4];

    pmod_audio_axi_regs dut (
        .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .audio_enable(audio_enable), .audio_mute(audio_mute), .audio_volume(audio_volume),
        .audio_clkdiv(audio_clkdiv), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok;
        bit w_ok;
        int n;
        aw_ok = 0;
        w_ok = 0;
        n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_ok && w_ok) && n < 20) begin
            @(negedge aclk);
            if (awvalid && awready) aw_ok = 1;
            if (wvalid && wready) w_ok = 1;
            tick();
            if (aw_ok) awvalid = 0;
            if (w_ok) wvalid = 0;
            n++;
        end
        if (!(aw_ok && w_ok)) check("write_handshake_timeout", 32'd0, 32'd1);
        awvalid = 0; wvalid = 0; bready = 1; n = 0;
        @(negedge aclk);
        while (!bvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("bvalid", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, 32'd0);
        tick();
        bready = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        int n;
        n = 0;
        araddr = a; arvalid = 1;
        do begin
            @(negedge aclk);
            n++;
        end while (!arready && n < 20);
        if (!arready) begin
            check({name, "_ar_timeout"}, 32'd0, 32'd1);
            arvalid = 0;
            return;
        end
        exp_q.push_back(exp);
        tick();
        arvalid = 0; rready = 1; n = 0;
        @(negedge aclk);
        while (!rvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(name, rdata, exp_q.pop_front());
        check({name, "_rresp"}, {30'd0, rresp}, 32'd0);
        tick();
        rready = 0;
    endtask

    task automatic pulse_tx_ready();
        tx_ready = 1;
        tick();
        tx_ready = 0;
    endtask

    initial begin
        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0000, 4'hF, 32'h0000_0001};
        aresetn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; tx_ready = 0;

        // reset state
        repeat (3) tick();
        @(negedge aclk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_clkdiv", {16'd0, audio_clkdiv}, 32'h7);
        tick();
        aresetn = 1;
        tick();
        @(negedge aclk);
        check("post_rst_awready", {31'd0, awready}, 32'd1);
        check("post_rst_wready", {31'd0, wready}, 32'd1);
        check("post_rst_arready", {31'd0, arready}, 32'd1);
        tick();

        // basic write/readback from the vector table
        foreach (vecs[i]) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
        foreach (vecs[i]) axi_read(vecs[i].addr, vecs[i].exp, $sformatf("table_rd%0d", i));

        // sample handshake and overrun
        pulse_tx_ready();
        axi_read(4'hC, 32'h0, "status_drained");
        axi_write(4'h8, 32'hA5A5A5A5, 4'hF);
        check("tx_valid_a5", {31'd0, tx_valid}, 32'd1);
        check("tx_data_a5", tx_data, 32'hA5A5A5A5);
        axi_write(4'h8, 32'h5A5A5A5A, 4'hF);
        axi_read(4'hC, 32'h3, "status_overrun");
        check("tx_data_5a", tx_data, 32'h5A5A5A5A);
        pulse_tx_ready();
        axi_read(4'hC, 32'h2, "status_consumed");
        axi_write(4'hC, 32'h2, 4'h1);
        axi_read(4'hC, 32'h0, "status_w1c");

        // TX commit on the same edge as the core consumes the old sample
        axi_write(4'h8, 32'h11, 4'hF);
        awaddr = 4'h8; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1; tx_ready = 1;
        @(negedge aclk);
        check("coinc_awready", {31'd0, awready}, 32'd1);
        check("coinc_wready", {31'd0, wready}, 32'd1);
        tick();
        awvalid = 0; wvalid = 0; tx_ready = 0; bready = 1;
        @(negedge aclk);
        check("coinc_bvalid", {31'd0, bvalid}, 32'd1);
        check("coinc_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("coinc_tx_data", tx_data, 32'h22);
        tick();
        bready = 0;
        axi_read(4'hC, 32'h1, "status_coinc_no_ovr");
        pulse_tx_ready();

        // CTRL byte strobes
        axi_write(4'h0, 32'hFFFFFFFF, 4'hF);
        axi_read(4'h0, 32'h0000FF03, "ctrl_all_ones");
        axi_write(4'h0, 32'h00000000, 4'b0010);
        axi_read(4'h0, 32'h00000003, "ctrl_strb_byte1");
        check("audio_volume", {24'd0, audio_volume}, 32'h0);
        check("audio_enable", {31'd0, audio_enable}, 32'd1);
        check("audio_mute", {31'd0, audio_mute}, 32'd1);
        axi_write(4'h8, 32'h0000_1234, 4'b0000);
        check("tx_strb0_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_strb0_data", tx_data, 32'h22);
        pulse_tx_ready();

        // reset while AW is latched and W not yet sent
        awaddr = 4'h4; awvalid = 1;
        @(negedge aclk);
        check("rstaw_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 0; aresetn = 0;
        repeat (2) tick();
        aresetn = 1;
        tick();
        @(negedge aclk);
        check("rstaw_bvalid", {31'd0, bvalid}, 32'd0);
        check("rstaw_clkdiv", {16'd0, audio_clkdiv}, 32'h7);
        check("rstaw_enable", {31'd0, audio_enable}, 32'd0);
        check("rstaw_tx_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        wdata = 32'hBEEF; wstrb = 4'hF; wvalid = 1;
        @(negedge aclk);
        check("rstaw_wready", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 0;
        repeat (2) begin
            @(negedge aclk);
            check("rstaw_no_commit", {31'd0, bvalid}, 32'd0);
            tick();
        end
        axi_read(4'h4, 32'h7, "rstaw_clkdiv_rd");
        awaddr = 4'h4; awvalid = 1;
        @(negedge aclk);
        check("rstaw_aw2_ready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 0; bready = 1;
        @(negedge aclk);
        check("rstaw_late_bvalid", {31'd0, bvalid}, 32'd1);
        tick();
        bready = 0;
        axi_read(4'h4, 32'hBEEF, "rstaw_clkdiv_new");

        // W three cycles ahead of AW, BREADY held off
        wdata = 32'h1234; wstrb = 4'hF; wvalid = 1;
        @(negedge aclk);
        check("wfirst_wready", {31'd0, wready}, 32'd1);
        tick();
        wvalid = 0;
        repeat (2) begin
            @(negedge aclk);
            check("wfirst_wready_low", {31'd0, wready}, 32'd0);
            check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
            tick();
        end
        awaddr = 4'h4; awvalid = 1;
        @(negedge aclk);
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 0;
        repeat (5) begin
            @(negedge aclk);
            check("wfirst_bvalid_held", {31'd0, bvalid}, 32'd1);
            check("wfirst_awready_low", {31'd0, awready}, 32'd0);
            check("wfirst_wready_low2", {31'd0, wready}, 32'd0);
            tick();
        end
        bready = 1;
        tick();
        bready = 0;
        @(negedge aclk);
        check("wfirst_bvalid_clr", {31'd0, bvalid}, 32'd0);
        check("wfirst_awready_back", {31'd0, awready}, 32'd1);
        check("wfirst_clkdiv", {16'd0, audio_clkdiv}, 32'h1234);
        tick();
        axi_read(4'h4, 32'h1234, "wfirst_rd");

        // read and write to the same register on the same edge
        awaddr = 4'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 4'h4; arvalid = 1;
        @(negedge aclk);
        check("same_awready", {31'd0, awready}, 32'd1);
        check("same_arready", {31'd0, arready}, 32'd1);
        exp_q.push_back(32'h1234);
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        @(negedge aclk);
        check("same_bvalid", {31'd0, bvalid}, 32'd1);
        check("same_rvalid", {31'd0, rvalid}, 32'd1);
        check("same_rdata_old", rdata, exp_q.pop_front());
        tick();
        bready = 0; rready = 0;
        axi_read(4'h4, 32'h55, "same_rd_new");

        // back-to-back reads with RREADY stalled
        axi_write(4'h0, 32'h0000_0102, 4'hF);
        araddr = 4'h4; arvalid = 1;
        @(negedge aclk);
        check("b2b_arready1", {31'd0, arready}, 32'd1);
        exp_q.push_back(32'h55);
        tick();
        araddr = 4'h0;
        repeat (4) begin
            @(negedge aclk);
            check("b2b_rvalid_stall", {31'd0, rvalid}, 32'd1);
            check("b2b_rdata_stall", rdata, exp_q[0]);
            check("b2b_arready_low", {31'd0, arready}, 32'd0);
            tick();
        end
        rready = 1;
        @(negedge aclk);
        check("b2b_rd1", rdata, exp_q.pop_front());
        tick();
        @(negedge aclk);
        check("b2b_arready2", {31'd0, arready}, 32'd1);
        check("b2b_rvalid_gap", {31'd0, rvalid}, 32'd0);
        exp_q.push_back(32'h0000_0102);
        tick();
        arvalid = 0;
        @(negedge aclk);
        check("b2b_rvalid2", {31'd0, rvalid}, 32'd1);
        check("b2b_rd2", rdata, exp_q.pop_front());
        tick();
        rready = 0;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
